// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared widths, the NOP encoding and the fetch-state type used by
//             the instruction fetch unit and its FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DEF_ADDR_WIDTH  = 5;
    localparam int DEF_INSTR_WIDTH = 8;

    localparam logic [7:0] NOP_INSTR = 8'h00;

    // IDLE: nothing outstanding; REQ: live request; FLUSH: request whose data is discarded
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_if.sv
// ============================================================================
//  Module   : instruction_fetch_if
//  Purpose  : Program-memory read port, instruction handshake and control
//             (jump/halt) bundle. master = fetch unit, slave = environment.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_if
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
);
    logic                   mem_req;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic                   mem_ack;
    logic [INSTR_WIDTH-1:0] mem_rdata;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   jump;
    logic [ADDR_WIDTH-1:0]  jump_addr;
    logic                   halt;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, pc,
        input  mem_ack, mem_rdata, instr_ready, jump, jump_addr, halt
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, pc,
        output mem_ack, mem_rdata, instr_ready, jump, jump_addr, halt
    );

endinterface

`default_nettype wire

// File: rtl/ifetch_fifo.sv
// ============================================================================
//  Module   : ifetch_fifo
//  Purpose  : Small synchronous FIFO of {instr, pc} entries with clear.
//             Head entry comes straight from flop storage. A push into a
//             full FIFO is accepted when a pop happens on the same edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 13
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   i_clear,
    input  wire logic                   i_push,
    input  wire logic                   i_pop,
    input  wire logic [WIDTH-1:0]       i_data,
    output logic      [WIDTH-1:0]       o_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic      [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy bookkeeping; clear wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Entry storage, zeroed on reset so the head reads 0 while empty after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
//  Module   : instruction_fetch
//  Purpose  : Fetches bytes from program memory at an internal PC, buffers
//             them with their address and delivers them over valid/ready.
//             Handles jump redirection (stale data discarded) and halt.
//  Config   : IFETCH_ZERO_SKIP_EN - when defined, acked NOP (8'h00) words are
//             not buffered; the PC still advances.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int FIFO_DEPTH  = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    instruction_fetch_if.master   bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = INSTR_WIDTH + ADDR_WIDTH;

    fetch_state_e          r_state;
    fetch_state_e          w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] w_fetch_pc_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  w_keep;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_count_after;
    logic [EW-1:0]         w_head;

`ifdef IFETCH_ZERO_SKIP_EN
    assign w_keep = (bus.mem_rdata != INSTR_WIDTH'(NOP_INSTR));
`else
    assign w_keep = 1'b1;
`endif

    // Only a live (non-flushed) ack not cancelled by a simultaneous jump is buffered
    assign w_push = (r_state == ST_REQ) && bus.mem_ack && !bus.jump && w_keep
                    && (!w_full || w_pop);
    assign w_pop  = !w_empty && bus.instr_ready;

    // Occupancy after this edge decides whether another request fits
    assign w_count_after = bus.jump ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
    assign w_issue       = !bus.halt && (w_count_after < CW'(FIFO_DEPTH));

    // Next fetch address: jump target wins, a live ack advances with wrap
    assign w_fetch_pc_nxt = bus.jump                                ? bus.jump_addr :
                            ((r_state == ST_REQ) && bus.mem_ack)    ? r_fetch_pc + ADDR_WIDTH'(1) :
                                                                      r_fetch_pc;

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (bus.jump),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({bus.mem_rdata, bus.mem_addr}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Fetch state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: one request at a time, jump without ack turns REQ into FLUSH
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = w_issue ? ST_REQ : ST_IDLE;
            ST_REQ: begin
                if (bus.mem_ack)   w_state_nxt = w_issue ? ST_REQ : ST_IDLE;
                else if (bus.jump) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (bus.mem_ack)   w_state_nxt = w_issue ? ST_REQ : ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Fetch PC and request address; the address is frozen until its ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= '0;
            r_mem_addr <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            if (w_state_nxt == ST_REQ) r_mem_addr <= w_fetch_pc_nxt;
        end
    end

    // Outputs: request from state, instruction/pc straight from the FIFO head
    always_comb begin
        bus.mem_req             = (r_state != ST_IDLE);
        bus.mem_addr            = r_mem_addr;
        bus.instr_valid         = !w_empty;
        {bus.instr, bus.pc}     = w_head;
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit: issues byte reads to program memory from an internal program counter, buffers the returned 8-bit instructions in a small FIFO, and presents them to the instruction register/controller through a valid/ready handshake. It is the supplying end of the instruction-register path. It also handles jump redirection and halting, and never delivers a stale instruction after a redirect.

## Interface
- ADDR_WIDTH, 5, program memory address width; PC wraps modulo 2^ADDR_WIDTH
- INSTR_WIDTH, 8, instruction width (opcode [7:4], data [3:0])
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2)
- clock  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-low; logic is in reset while reset=0
- mem_req  out  1  read request to program memory
- mem_addr  out  ADDR_WIDTH  read address, stable while mem_req=1
- mem_ack  in  1  memory completes the request on this edge
- mem_rdata  in  INSTR_WIDTH  read data, valid when mem_ack=1
- instr_valid  out  1  instr/pc hold a valid instruction
- instr_ready  in  1  consumer accepts the instruction on this edge
- instr  out  INSTR_WIDTH  instruction at FIFO head
- pc  out  ADDR_WIDTH  address the head instruction was fetched from
- jump  in  1  redirect fetch to jump_addr (one-cycle pulse)
- jump_addr  in  ADDR_WIDTH  redirect target
- halt  in  1  level; while high no new requests are issued

## Operation
- FSM states: IDLE (no request outstanding), REQ (mem_req=1, waiting for ack), FLUSH (mem_req=1, waiting for ack whose data is discarded).
- IDLE→REQ when halt=0 and the FIFO has a free slot counting the request to be issued. mem_addr=fetch_pc.
- REQ, mem_ack=1: push {mem_rdata, mem_addr}, fetch_pc+=1 (wrap), then go to REQ again if the issue condition still holds, else IDLE.
- At most one request outstanding. mem_req/mem_addr are never withdrawn before mem_ack.
- Jump (priority over everything): FIFO cleared, instr_valid=0 next cycle, fetch_pc=jump_addr. From REQ without ack → FLUSH. In REQ with ack on the same edge → data dropped, → IDLE/REQ at jump_addr. From IDLE → normal issue at jump_addr.
- FLUSH, mem_ack=1: data dropped, → issue at jump_addr. A second jump in FLUSH updates the target only.
- Pop on instr_valid & instr_ready. Push and pop on the same edge are both honoured when the FIFO is full.
- halt: the outstanding request completes and is buffered, and buffered instructions still drain. Issuing resumes the cycle after halt falls.
- Reset: state IDLE, FIFO empty, fetch_pc=0. mem_req=0, mem_addr=0, instr_valid=0, instr=0, pc=0. Reset mid-request abandons it; the memory is reset by the same signal.

## Timing
- First mem_req is high in the cycle after the first posedge with reset=1.
- Ack at edge N → instr_valid=1 after edge N (registered FIFO, 1-cycle latency). A back-to-back request is driven after edge N.
- Sustained throughput is one instruction per memory ack when the consumer is always ready.
- instr/pc hold steady while instr_valid=1 and instr_ready=0.
- jump at edge N → instr_valid=0 after edge N. The first target instruction appears one cycle after its ack.

## Configuration
- IFETCH_ZERO_SKIP_EN defined: acked words equal to 8'h00 (NOP) are not pushed. The PC still advances, and the slot is freed for issue.
- Undefined: every acked word is pushed and delivered, including 8'h00.

## Structure
- cpu_pkg holds: default ADDR_WIDTH/INSTR_WIDTH, NOP_INSTR=8'h00, and the fetch-state enum {IDLE, REQ, FLUSH}.
- Sub-module ifetch_fifo: synchronous FIFO of {instr, pc} with clear, push, pop, full, empty and count. It has registered outputs and is reset to empty.

## Test plan
- Reset release, memory returns 8'h31,8'h52,8'h7F with ack 1 cycle after req, consumer always ready → instr 31/52/7F, pc 0/1/2.
- Consumer ready=0 for 10 cycles → mem_req stops after FIFO_DEPTH acks, instr holds 8'h31. Raise ready → in-order drain with no loss.
- Jump to 5'h10 while a req at 5'h03 is pending and acked 3 cycles later → that data is never delivered, and the next mem_addr is 5'h10.
- fetch_pc=5'h1F, ack → next mem_addr=5'h00, and pc output shows 1F then 00.
- Word 8'h00 at address 2: macro defined → delivered sequence skips it (pc jumps 1→3). Undefined → 8'h00 is delivered with pc=2.
- halt=1 mid-request → that ack is buffered and no further mem_req. Drop halt → mem_req is high the next cycle. Reset=0 mid-request → all outputs are 0 immediately.
